acc_datapath: RTL
=================

Name: acc_datapath

Overview:
- Datapath stage of the single-accumulator processor, directly downstream of the control decoder.
- Consumes the decoder's alu[4:0], muxa/muxb/muxc, en_ir/en_da/en_pc and rw strobes.
- Holds the instruction register (IR), accumulator (ACC), program counter (PC) and output port latch, and contains the ALU.
- Returns ir, carry and zero to the decoder and drives the memory and I/O buses.

Parameters:
- DW, 8, data/accumulator/IR width (IR fixed at 8 bits: opcode ir[7:4], operand ir[3:0]).
- AW, 8, program-counter and memory-address width; operand zero-extended to AW.

Ports:
- clk  in  1  clock, all registers update on posedge.
- clr  in  1  asynchronous, active-low reset.
- alu  in  5  ALU function code from decoder.
- muxa  in  1  A-operand select: 1=PC (zero-extended/truncated to DW), 0=ACC.
- muxb  in  1  B/address select: 1=mem_rdata and mem_addr=operand; 0=operand immediate and mem_addr=PC.
- muxc  in  1  I/O select: 1=B operand is io_rdata (overrides muxb for B only).
- en_ir  in  1  load IR from mem_rdata.
- en_da  in  1  load ACC from ALU result.
- en_pc  in  1  load PC from ALU result (low AW bits).
- rw  in  1  output-port write strobe.
- mem_rdata  in  DW  memory read data (combinational w.r.t. mem_addr).
- io_rdata  in  DW  input-port data.
- ir  out  8  instruction register.
- carry  out  1  combinational ALU carry flag.
- zero  out  1  combinational ALU zero flag.
- mem_addr  out  AW  memory address.
- io_addr  out  4  I/O port number = ir[3:0].
- io_wdata  out  DW  output-port latch.
- io_wvalid  out  1  one-cycle pulse after an output-port write.
- pc  out  AW  program counter, for debug.
- acc  out  DW  accumulator, for debug.

Behaviour:
- Reset (clr=0, async): ir=0, ACC=0, PC=0, io_wdata=0, io_wvalid=0. Combinational outputs follow the reset register values. Release is synchronous to the next posedge.
- Operand select:
  - A = muxa ? PC : ACC.
  - B = muxc ? io_rdata : (muxb ? mem_rdata : zero-extended ir[3:0]).
  - mem_addr = muxb ? zero-extended ir[3:0] : PC.
- ALU (purely combinational, result Y of DW bits):
  - 00000 ADD: Y=A+B; carry=carry-out.
  - 00001 AND: Y=A&B; carry=0.
  - 00011 PASSB (load/input/jump): Y=B; carry=0.
  - 00010 PASSA (output): Y=A; carry=0.
  - 01100 SUB: Y=A+~B+1; carry=carry-out (1 = no borrow).
  - 10100 INC: Y=A+1; carry=carry-out.
  - Any other code: Y=0, carry=0.
  - zero = (Y==0) for every code, including undefined codes (so zero=1).
- Register updates at posedge, each independently enabled; simultaneous enables are all honoured in the same cycle:
  - en_ir: ir <= mem_rdata[7:0].
  - en_da: ACC <= Y.
  - en_pc: PC <= Y[AW-1:0]. Wraps modulo 2^AW, so 0xFF INC -> 0x00.
- Output port: on posedge with rw=1, io_wdata <= ACC and io_wvalid <= 1 in the next cycle only. Consecutive rw cycles give io_wvalid held high, with io_wdata updated each cycle.
- Latency:
  - carry/zero/mem_addr are valid in the same cycle as their inputs.
  - Register results are visible one cycle after the enable.
  - The decoder captures flags in the same cycle en_da fires.
- An overflowing ADD wraps to DW bits, with carry=1.
- Reset asserted mid-instruction clears all state immediately; the in-flight instruction is discarded.

Test Plan:
1. Reset: clr=0 with all enables high -> ir=0, acc=0, pc=0, io_wvalid=0; mem_addr=0; zero=1 (ALU code 00000, A=0, B=operand 0).
2. Fetch/increment: mem_rdata=0x43, en_ir=1 -> ir=0x43. Then muxa=1, alu=10100, en_pc=1 with pc=0x05 -> pc=0x06, carry=0.
3. Add overflow: acc=0xF0, muxb=1, ir operand=0x2, mem_rdata=0x20, alu=00000, en_da=1 -> mem_addr=0x02, carry=1, zero=0, acc=0x10.
4. Sub equal: acc=0x07, B immediate 0x7 (muxb=0), alu=01100, en_da=1 -> zero=1, carry=1, acc=0x00. Then acc=0x03, B=0x7 -> carry=0, acc=0xFC.
5. I/O: muxc=1, io_rdata=0x5A, alu=00011, en_da=1 -> acc=0x5A. Then rw=1 -> io_wdata=0x5A with a single io_wvalid pulse; io_addr=ir[3:0].
6. Jump/wrap and async reset: ir=0x8C, alu=00011, muxb=0, en_pc=1 -> pc=0x0C. Then pc=0xFF INC -> pc=0x00, carry=1. Drop clr between clock edges -> all registers 0 immediately.

Source files
------------

// File: rtl/acc_datapath.sv
// Accumulator-processor datapath: IR/ACC/PC/output latch plus the ALU. Flags and mem_addr
// are combinational, register results appear one cycle after their enable, and there is no backpressure.
module acc_datapath #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [4:0]    alu,
  input  logic          muxa,
  input  logic          muxb,
  input  logic          muxc,
  input  logic          en_ir,
  input  logic          en_da,
  input  logic          en_pc,
  input  logic          rw,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] io_rdata,
  output logic [7:0]    ir,
  output logic          carry,
  output logic          zero,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    io_addr,
  output logic [DW-1:0] io_wdata,
  output logic          io_wvalid,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] acc
);

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_AND   = 5'b00001;
  localparam logic [4:0] ALU_PASSA = 5'b00010;
  localparam logic [4:0] ALU_PASSB = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b01100;
  localparam logic [4:0] ALU_INC   = 5'b10100;
  localparam logic [DW:0] ONE      = (DW+1)'(1);

  logic [7:0]    ir_q,     ir_d;
  logic [DW-1:0] acc_q,    acc_d;
  logic [AW-1:0] pc_q,     pc_d;
  logic [DW-1:0] wdata_q,  wdata_d;
  logic          wvalid_q, wvalid_d;

  logic [DW-1:0] opa, opb, y;
  logic [DW:0]   res;

  always_comb begin
    opa = muxa ? DW'(pc_q) : acc_q;
    if (muxc)      opb = io_rdata;
    else if (muxb) opb = mem_rdata;
    else           opb = DW'(ir_q[3:0]);
  end

  // Extra top bit of res holds the carry-out; logical ops leave it clear.
  always_comb begin
    res = '0;
    case (alu)
      ALU_ADD:   res = {1'b0, opa} + {1'b0, opb};
      ALU_AND:   res = {1'b0, opa & opb};
      ALU_PASSA: res = {1'b0, opa};
      ALU_PASSB: res = {1'b0, opb};
      ALU_SUB:   res = {1'b0, opa} + {1'b0, ~opb} + ONE;
      ALU_INC:   res = {1'b0, opa} + ONE;
      default:   res = '0;
    endcase
    y = res[DW-1:0];
  end

  always_comb begin
    ir_d     = en_ir ? mem_rdata[7:0] : ir_q;
    acc_d    = en_da ? y : acc_q;
    pc_d     = en_pc ? y[AW-1:0] : pc_q;
    wdata_d  = rw ? acc_q : wdata_q;
    wvalid_d = rw;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ir_q     <= '0;
      acc_q    <= '0;
      pc_q     <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      acc_q    <= acc_d;
      pc_q     <= pc_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign carry     = res[DW];
  assign zero      = (y == '0);
  assign mem_addr  = muxb ? AW'(ir_q[3:0]) : pc_q;
  assign ir        = ir_q;
  assign io_addr   = ir_q[3:0];
  assign io_wdata  = wdata_q;
  assign io_wvalid = wvalid_q;
  assign pc        = pc_q;
  assign acc       = acc_q;

endmodule
